// File: rtl/ibex_register_file_ff_mp.sv
// Multi-port flip-flop register file with a per-register pending scoreboard and write-collision flag.
// Optional IBEX_RF_PARITY_EN adds an even-parity bit per register, checked on every read port.
module ibex_register_file_ff_mp #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumRead     = 2,
  parameter int unsigned          NumWrite    = 2,
  parameter bit                   WriteBypass = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRead*5-1:0]          raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rpend_o,
  input  logic [NumWrite*5-1:0]         waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          rsv_i,
  input  logic [4:0]                    rsv_addr_i,
  output logic [5:0]                    pend_cnt_o,
  output logic                          err_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumRegs   = 2 ** AddrWidth;

  typedef logic [AddrWidth-1:0] addr_t;

  addr_t                ra [NumRead];
  addr_t                wa [NumWrite];
  addr_t                rsv_a;
  logic [NumWrite-1:0]  wv;
  logic                 rsv_v;
  logic                 unused_addr_hi;

  logic [DataWidth-1:0] rf_q [1:NumRegs-1];
  logic [DataWidth-1:0] rf_d [1:NumRegs-1];
  logic [NumRegs-1:1]   pend_q, pend_d;
  logic [5:0]           pend_cnt_q, pend_cnt_d;
  logic                 err_q, err_d;
  logic                 coll;
  logic                 par_err;
  logic [NumRead-1:0]   byp_hit;

  // Only the low AddrWidth bits select a register; upper bits are dropped on RV32E.
  assign unused_addr_hi = ^{raddr_i, waddr_i, rsv_addr_i};

  always_comb begin
    for (int p = 0; p < NumRead; p++) ra[p] = raddr_i[5*p +: AddrWidth];
    for (int w = 0; w < NumWrite; w++) begin
      wa[w] = waddr_i[5*w +: AddrWidth];
      wv[w] = we_i[w] && (wa[w] != '0);
    end
    rsv_a = rsv_addr_i[AddrWidth-1:0];
    rsv_v = rsv_i && (rsv_a != '0);
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    rf_d   = rf_q;
    pend_d = pend_q;
    coll   = 1'b0;
    for (int w = 0; w < NumWrite; w++) begin
      if (wv[w]) begin
        rf_d[wa[w]]   = wdata_i[w*DataWidth +: DataWidth];
        pend_d[wa[w]] = 1'b0;
      end
    end
    for (int i = 0; i < NumWrite; i++) begin
      for (int j = i + 1; j < NumWrite; j++) begin
        if (wv[i] && wv[j] && (wa[i] == wa[j])) coll = 1'b1;
      end
    end
    if (rsv_v) pend_d[rsv_a] = 1'b1;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 1; i < NumRegs; i++) pend_cnt_d = pend_cnt_d + 6'(pend_q[i]);
  end

  assign err_d = coll | par_err;

  always_comb begin
    rdata_o = '0;
    rpend_o = '0;
    byp_hit = '0;
    for (int p = 0; p < NumRead; p++) begin
      rdata_o[p*DataWidth +: DataWidth] = WordZeroVal;
      if (ra[p] != '0) begin
        rdata_o[p*DataWidth +: DataWidth] = rf_q[ra[p]];
        rpend_o[p] = pend_q[ra[p]];
        if (WriteBypass) begin
          for (int w = 0; w < NumWrite; w++) begin
            if (wv[w] && (wa[w] == ra[p])) begin
              rdata_o[p*DataWidth +: DataWidth] = wdata_i[w*DataWidth +: DataWidth];
              byp_hit[p] = 1'b1;
            end
          end
          // A same-cycle reserve means a new producer is outstanding, so keep the flag.
          if (byp_hit[p] && !(rsv_v && (rsv_a == ra[p]))) rpend_o[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumRegs; i++) rf_q[i] <= WordZeroVal;
      pend_q     <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef IBEX_RF_PARITY_EN
  logic [NumRegs-1:1] par_q, par_d;

  always_comb begin
    par_d = par_q;
    for (int w = 0; w < NumWrite; w++) begin
      if (wv[w]) par_d[wa[w]] = ^wdata_i[w*DataWidth +: DataWidth];
    end
  end

  // Checked against stored data only; bypassed write data is never covered.
  always_comb begin
    par_err = 1'b0;
    for (int p = 0; p < NumRead; p++) begin
      if ((ra[p] != '0) && ((^rf_q[ra[p]]) != par_q[ra[p]])) par_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= {(NumRegs-1){^WordZeroVal}};
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign pend_cnt_o = pend_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_register_file_ff_mp.sv
// Directed bench for ibex_register_file_ff_mp in its default configuration (32 regs, 2R/2W, bypass on).
module tb_ibex_register_file_ff_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rpend;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic [5:0]  pend_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  ibex_register_file_ff_mp dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .raddr_i    (raddr),
    .rdata_o    (rdata),
    .rpend_o    (rpend),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .we_i       (we),
    .rsv_i      (rsv),
    .rsv_addr_i (rsv_addr),
    .pend_cnt_o (pend_cnt),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    raddr = '0; waddr = '0; wdata = '0; we = '0; rsv = 1'b0; rsv_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    raddr = {5'd0, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 64'h0); end
    checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL reset_rpend got %b exp %b", rpend, 2'b00); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL post_reset_rdata got %h exp %h", rdata, 64'h0); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    idle();
    raddr = {5'd7, 5'd3};
    we    = 2'b11;
    waddr = {5'd7, 5'd3};
    wdata = {32'h12345678, 32'hDEADBEEF};
    #1;
    checks++; if (rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_x3 got %h exp deadbeef", rdata[31:0]); end
    checks++; if (rdata[63:32] !== 32'h12345678) begin errors++; $display("FAIL bypass_x7 got %h exp 12345678", rdata[63:32]); end
    @(negedge clk);
    we = 2'b00;
    #1;
    checks++; if (rdata !== {32'h12345678, 32'hDEADBEEF}) begin errors++; $display("FAIL stored_x3_x7 got %h exp %h", rdata, {32'h12345678, 32'hDEADBEEF}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL no_coll_err got %b exp 0", err); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle();
    raddr = {5'd9, 5'd9};
    we    = 2'b11;
    waddr = {5'd9, 5'd9};
    wdata = {32'h2, 32'h1};
    #1;
    checks++; if (rdata[31:0] !== 32'h2) begin errors++; $display("FAIL coll_bypass got %h exp 2", rdata[31:0]); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL coll_err_pulse got %b exp 1", err); end
    @(negedge clk);
    we = 2'b00;
    #1;
    checks++; if (rdata[31:0] !== 32'h2) begin errors++; $display("FAIL coll_winner got %h exp 2", rdata[31:0]); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_err_clear got %b exp 0", err); end
    @(negedge clk);
    raddr = '0;
    waddr = '0;
    wdata = {32'h2, 32'h1};
    we    = 2'b11;
    #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rdata); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL x0_coll_err got %b exp 0", err); end
    @(negedge clk);
    we = 2'b00;
    #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL x0_read got %h exp 0", rdata); end
  endtask

  task automatic test_pending();
    @(negedge clk);
    idle();
    rsv = 1'b1; rsv_addr = 5'd4;
    raddr = {5'd0, 5'd4};
    #1;
    checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL rsv_pre_edge got %b exp 00", rpend); end
    @(negedge clk);
    rsv = 1'b0;
    #1;
    checks++; if (rpend !== 2'b01) begin errors++; $display("FAIL rsv_pend got %b exp 01", rpend); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL rsv_cnt_lag got %0d exp 0", pend_cnt); end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL rsv_cnt got %0d exp 1", pend_cnt); end
    @(negedge clk);
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hA5};
    #1;
    checks++; if (rdata[31:0] !== 32'hA5) begin errors++; $display("FAIL wr_x4_bypass got %h exp a5", rdata[31:0]); end
    checks++; if (rpend[0] !== 1'b0) begin errors++; $display("FAIL wr_mask_pend got %b exp 0", rpend[0]); end
    @(negedge clk);
    we = 2'b00;
    #1;
    checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL wr_clear_pend got %b exp 00", rpend); end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL wr_clear_cnt got %0d exp 0", pend_cnt); end
    @(negedge clk);
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h77};
    rsv = 1'b1; rsv_addr = 5'd4;
    @(negedge clk);
    we = 2'b00; rsv = 1'b0;
    #1;
    checks++; if (rpend !== 2'b01) begin errors++; $display("FAIL wr_rsv_set_wins got %b exp 01", rpend); end
    checks++; if (rdata[31:0] !== 32'h77) begin errors++; $display("FAIL wr_rsv_data got %h exp 77", rdata[31:0]); end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL wr_rsv_cnt got %0d exp 1", pend_cnt); end
    @(negedge clk);
    rsv = 1'b1; rsv_addr = 5'd4;
    @(negedge clk);
    rsv = 1'b0;
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL re_rsv_cnt got %0d exp 1", pend_cnt); end
    @(negedge clk);
    we = 2'b10; waddr = {5'd4, 5'd0}; wdata = {32'h99, 32'h0};
    rsv = 1'b1; rsv_addr = 5'd4;
    #1;
    checks++; if (rpend[0] !== 1'b1) begin errors++; $display("FAIL wr_rsv_unmask got %b exp 1", rpend[0]); end
    @(negedge clk);
    we = 2'b00;
    rsv = 1'b1; rsv_addr = 5'd0;
    raddr = '0;
    @(negedge clk);
    rsv = 1'b0;
    #1;
    checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL x0_never_pend got %b exp 00", rpend); end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL x0_rsv_cnt got %0d exp 1", pend_cnt); end
  endtask

  task automatic test_fill();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rsv = 1'b1; rsv_addr = 5'(i);
    end
    @(negedge clk);
    rsv = 1'b0;
    raddr = {5'd31, 5'd1};
    #1;
    checks++; if (rpend !== 2'b11) begin errors++; $display("FAIL fill_rpend got %b exp 11", rpend); end
    checks++; if (pend_cnt !== 6'd30) begin errors++; $display("FAIL fill_cnt_lag got %0d exp 30", pend_cnt); end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd31) begin errors++; $display("FAIL fill_cnt got %0d exp 31", pend_cnt); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'h0, 32'h55};
    @(negedge clk);
    we = 2'b00;
    raddr = {5'd3, 5'd12};
    #1;
    checks++; if (rdata[31:0] !== 32'h55) begin errors++; $display("FAIL pre_rst_x12 got %h exp 55", rdata[31:0]); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      rsv = 1'b1; rsv_addr = 5'(i);
    end
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd9) begin errors++; $display("FAIL mid_cnt got %0d exp 9", pend_cnt); end
    @(negedge clk);
    rsv_addr = 5'd11;
    we = 2'b01; waddr = {5'd0, 5'd13}; wdata = {32'h0, 32'h66};
    rst_n = 1'b0;
    #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", pend_cnt); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0", rdata); end
    checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL mid_rst_rpend got %b exp 00", rpend); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    raddr = {5'd13, 5'd11};
    #1;
    checks++; if ({rdata, rpend} !== 66'h0) begin errors++; $display("FAIL mid_rst_dropped got %h exp 0", {rdata, rpend}); end
  endtask

  task automatic test_parity();
    @(negedge clk);
    idle();
    we = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h3};
    @(negedge clk);
    we = 2'b00;
    raddr = {5'd6, 5'd6};
`ifdef IBEX_RF_PARITY_EN
    dut.rf_q[6] = 32'h2;
`endif
    @(posedge clk); #1;
`ifdef IBEX_RF_PARITY_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL parity_err got %b exp 1", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL parity_absent_err got %b exp 0", err); end
    checks++; if (rdata !== {32'h3, 32'h3}) begin errors++; $display("FAIL x6_read got %h exp %h", rdata, {32'h3, 32'h3}); end
`endif
  endtask

  initial begin
    idle();
    test_reset();
    test_dual_write();
    test_collision();
    test_pending();
    test_fill();
    test_mid_reset();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
